pifo_drain: RTL

// - Dequeue side of the PIFO flow scheduler. It issues pops, captures the returned values and

---
 rtl/pifo_pkg.sv | 10 +
 rtl/pifo_sync_fifo.sv | 78 +++++++
 rtl/pifo_drain.sv | 95 +++++++++
 3 files changed

// File: rtl/pifo_pkg.sv
// Types shared between the PIFO flow scheduler and its dequeue-side drain.
package pifo_pkg;

    localparam int VALUE_W = 32;
    localparam int RANK_W  = 32;

    typedef logic [VALUE_W-1:0] pifo_value_t;
    typedef logic [RANK_W-1:0]  pifo_rank_t;

endpackage

// File: rtl/pifo_sync_fifo.sv
// Small synchronous FIFO with a registered head word; full/empty come from count.
module pifo_sync_fifo
    import pifo_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = pifo_value_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  T                 wr_data,
    input  logic             rd_en,
    output T                 rd_data,
    output logic [CNT_W-1:0] count
);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    T                 head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = head_q;
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head is taken from the post-write image so a write into an emptying
        // buffer lands on the head register without a bypass mux downstream.
        head_d = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !rd_en)) else $error("pifo_sync_fifo overflow");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && empty)) else $error("pifo_sync_fifo underflow");

endmodule

// File: rtl/pifo_drain.sv
// Dequeue side of the PIFO scheduler: rate-limited pop issue, response capture
// into a small buffer, and a valid/ready egress stream with an accept counter.
module pifo_drain
    import pifo_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TOKEN_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_enable,
    input  logic [TOKEN_W-1:0] cfg_cost,
    input  logic [TOKEN_W-1:0] cfg_burst,
    output logic               sched_pop,
    input  logic               sched_pop_valid,
    input  pifo_value_t        sched_pop_value,
    input  logic               sched_is_empty,
    output logic               out_valid,
    input  logic               out_ready,
    output pifo_value_t        out_value,
    output logic [31:0]        drained_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]   occupancy;
    logic [CNT_W:0]     committed;
    logic               wr_en, rd_en, credit_ok, token_ok;
    logic               inflight_q, inflight_d;
    logic               last_pop_q, last_pop_d;
    logic [TOKEN_W-1:0] tokens_q, tokens_d;
    logic [TOKEN_W:0]   tok_inc, tok_cap, tok_after;
    logic [31:0]        drained_count_q, drained_count_d;

    pifo_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (pifo_value_t)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (sched_pop_value),
        .rd_en   (rd_en),
        .rd_data (out_value),
        .count   (occupancy)
    );

    always_comb begin
        // A response with nothing outstanding (e.g. stale strobe after reset) is dropped.
        wr_en     = sched_pop_valid && inflight_q;
        out_valid = (occupancy != '0);
        rd_en     = out_valid && out_ready;

        committed = {1'b0, occupancy} + {{CNT_W{1'b0}}, inflight_q};
        credit_ok = (committed < (CNT_W+1)'(DEPTH));
        token_ok  = (cfg_cost == '0) || (tokens_q >= cfg_cost);
        // last_pop spaces pops by two cycles to cover the scheduler's is_empty lag.
        sched_pop = cfg_enable && !sched_is_empty && !last_pop_q && credit_ok && token_ok;

        last_pop_d = sched_pop;
        inflight_d = inflight_q;
        if (sched_pop) begin
            inflight_d = 1'b1;
        end else if (sched_pop_valid) begin
            inflight_d = 1'b0;
        end

        tok_inc   = {1'b0, tokens_q} + 1'b1;
        tok_cap   = (tok_inc > {1'b0, cfg_burst}) ? {1'b0, cfg_burst} : tok_inc;
        tok_after = tok_cap;
        if (sched_pop && (cfg_cost != '0)) begin
            tok_after = (tok_cap >= {1'b0, cfg_cost}) ? (tok_cap - {1'b0, cfg_cost}) : '0;
        end
        tokens_d = tok_after[TOKEN_W] ? '1 : tok_after[TOKEN_W-1:0];

        drained_count_d = drained_count_q + (rd_en ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            last_pop_q      <= 1'b0;
            tokens_q        <= '0;
            drained_count_q <= '0;
        end else begin
            inflight_q      <= inflight_d;
            last_pop_q      <= last_pop_d;
            tokens_q        <= tokens_d;
            drained_count_q <= drained_count_d;
        end
    end

    assign drained_count = drained_count_q;

endmodule
